// File: rtl/toy_dtcm_arb_if.sv
// Bundle of requester-side and memory-side signals around the DTCM arbiter.
// The slave modport is the arbiter's view; master is the environment's view
// (the LSU/debug requesters plus the DTCM macro).
interface toy_dtcm_arb_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SB_WIDTH   = 8
);
    // Requester side
    logic [NUM_REQ-1:0]                  req_vld;
    logic [NUM_REQ-1:0]                  req_rdy;
    logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]       req_wr_data;
    logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wr_byte_en;
    logic [NUM_REQ-1:0]                  req_wr_en;
    logic [NUM_REQ*SB_WIDTH-1:0]         req_sideband;
    logic [NUM_REQ-1:0]                  rsp_vld;
    logic [DATA_WIDTH-1:0]               rsp_data;
    logic [SB_WIDTH-1:0]                 rsp_sideband;

    // Memory side
    logic                                mem_en;
    logic [ADDR_WIDTH-1:0]               mem_addr;
    logic [DATA_WIDTH-1:0]               mem_wr_data;
    logic [DATA_WIDTH/8-1:0]             mem_wr_byte_en;
    logic                                mem_wr_en;
    logic [DATA_WIDTH-1:0]               mem_rd_data;

    modport slave (
        input  req_vld, req_addr, req_wr_data, req_wr_byte_en, req_wr_en,
               req_sideband, mem_rd_data,
        output req_rdy, rsp_vld, rsp_data, rsp_sideband,
               mem_en, mem_addr, mem_wr_data, mem_wr_byte_en, mem_wr_en
    );

    modport master (
        output req_vld, req_addr, req_wr_data, req_wr_byte_en, req_wr_en,
               req_sideband, mem_rd_data,
        input  req_rdy, rsp_vld, rsp_data, rsp_sideband,
               mem_en, mem_addr, mem_wr_data, mem_wr_byte_en, mem_wr_en
    );
endinterface

// File: rtl/toy_dtcm_arb.sv
// DTCM port arbiter: picks at most one of NUM_REQ requesters per cycle
// (round-robin, or fixed priority with anti-starvation), drives the single
// memory port from the winner, and routes fixed-latency read data back to
// the requester that issued the read.
module toy_dtcm_arb #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SB_WIDTH   = 8,
    parameter int RD_LAT     = 2,
    parameter int MAX_WAIT   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_rr_en,
    toy_dtcm_arb_if.slave     bus
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    // Saturating increment of a wait counter, clamped at MAX_WAIT.
    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
        if (v >= WCNT_W'(MAX_WAIT)) begin
            return WCNT_W'(MAX_WAIT);
        end
        return v + WCNT_W'(1);
    endfunction

    // Arbitration state
    logic [PTR_W-1:0]   rr_ptr;
    logic [WCNT_W-1:0]  wait_cnt [NUM_REQ];

    // Grant decision for the current cycle
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               rd_push;

    // Read-tracking pipeline: stage k holds a read granted k+1 cycles ago
    logic               rd_vld_p [RD_LAT];
    logic [PTR_W-1:0]   rd_src_p [RD_LAT];
    logic [SB_WIDTH-1:0] rd_sb_p [RD_LAT];

    // Pick the winner: starved requesters first (fixed mode only), then
    // either round-robin from rr_ptr or lowest index.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (!rst) begin
            if (!cfg_rr_en) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!gnt_any && bus.req_vld[i] &&
                        (wait_cnt[i] == WCNT_W'(MAX_WAIT))) begin
                        gnt_any = 1'b1;
                        gnt_idx = PTR_W'(i);
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!gnt_any && bus.req_vld[i]) begin
                        gnt_any = 1'b1;
                        gnt_idx = PTR_W'(i);
                    end
                end
            end else begin
                for (int off = 0; off < NUM_REQ; off++) begin
                    if (!gnt_any &&
                        bus.req_vld[(int'(rr_ptr) + off) % NUM_REQ]) begin
                        gnt_any = 1'b1;
                        gnt_idx = PTR_W'((int'(rr_ptr) + off) % NUM_REQ);
                    end
                end
            end
            if (gnt_any) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    assign bus.req_rdy = gnt;
    assign rd_push     = gnt_any && !bus.req_wr_en[gnt_idx];

    // Drive the memory port from the granted slice; all zero when idle.
    always_comb begin
        bus.mem_en         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wr_data    = '0;
        bus.mem_wr_byte_en = '0;
        bus.mem_wr_en      = 1'b0;
        if (gnt_any) begin
            bus.mem_en         = 1'b1;
            bus.mem_addr       = bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.mem_wr_data    = bus.req_wr_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            bus.mem_wr_byte_en = bus.req_wr_byte_en[int'(gnt_idx)*BE_W +: BE_W];
            bus.mem_wr_en      = bus.req_wr_en[gnt_idx];
        end
    end

    // Round-robin pointer moves past every winner, in either mode, so a
    // mode switch picks up from a sensible place.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
        end
    end

    // Count consecutive lost cycles per requester; cleared on grant or
    // when the requester drops its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_vld[i] && !gnt[i]) begin
                    wait_cnt[i] <= sat_inc(wait_cnt[i]);
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

    // Shift read bookkeeping along with the memory's own read latency;
    // reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                rd_vld_p[k] <= 1'b0;
                rd_src_p[k] <= '0;
                rd_sb_p[k]  <= '0;
            end
        end else begin
            // grant -> stage 0
            rd_vld_p[0] <= rd_push;
            rd_src_p[0] <= gnt_idx;
            rd_sb_p[0]  <= bus.req_sideband[int'(gnt_idx)*SB_WIDTH +: SB_WIDTH];
            // stage k-1 -> stage k
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld_p[k] <= rd_vld_p[k-1];
                rd_src_p[k] <= rd_src_p[k-1];
                rd_sb_p[k]  <= rd_sb_p[k-1];
            end
        end
    end

    // Last stage lines up with mem_rd_data: steer the response to its source.
    always_comb begin
        bus.rsp_vld      = '0;
        bus.rsp_data     = '0;
        bus.rsp_sideband = '0;
        if (!rst && rd_vld_p[RD_LAT-1]) begin
            bus.rsp_vld[rd_src_p[RD_LAT-1]] = 1'b1;
            bus.rsp_data                    = bus.mem_rd_data;
            bus.rsp_sideband                = rd_sb_p[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_toy_dtcm_arb.sv
// Bench for toy_dtcm_arb: directed scenarios followed by random traffic,
// checked cycle by cycle against a behavioural arbiter/memory model.
module tb_toy_dtcm_arb;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SBW = 8;
    localparam int LAT = 2;
    localparam int MW  = 7;

    logic clk = 1'b0;
    logic rst;
    logic cfg_rr_en;

    always #5 clk = ~clk;

    toy_dtcm_arb_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_WIDTH(SBW)) bus ();

    toy_dtcm_arb #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_WIDTH(SBW),
        .RD_LAT(LAT), .MAX_WAIT(MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_rr_en (cfg_rr_en),
        .bus       (bus)
    );

    typedef struct {
        int          due;
        int          src;
        logic [7:0]  sb;
        logic [31:0] data;
    } rsp_t;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Requester intent (held until granted)
    logic        pend  [N];
    logic        p_wr  [N];
    logic [31:0] p_addr[N];
    logic [31:0] p_data[N];
    logic [3:0]  p_be  [N];
    logic [7:0]  p_sb  [N];
    logic        rst_r;
    logic        cfg_r;

    // Reference model state
    int          m_rr;
    int          m_wcnt[N];
    rsp_t        exp_q[$];
    logic [31:0] m_mem[logic [31:0]];

    // Memory environment answering the DUT
    logic [31:0] e_mem[logic [31:0]];
    logic [31:0] e_pipe[LAT];

    // Observations for directed checks
    logic [N-1:0] obs_rdy;
    logic [N-1:0] rsp_log[$];
    logic [31:0]  last_rsp_data[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic post(input int i, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic [7:0] sb);
        pend[i] = 1'b1; p_wr[i] = wr; p_addr[i] = a;
        p_data[i] = d; p_be[i] = be; p_sb[i] = sb;
    endtask

    task automatic post_rand(input int i);
        post(i, ($urandom_range(0, 2) == 0), 32'($urandom_range(0, 127)) << 2,
             $urandom, 4'($urandom_range(0, 15)), 8'($urandom));
    endtask

    // One clock cycle: drive, predict, compare, advance model and memory.
    task automatic cycle();
        int           win;
        logic [N-1:0] exp_rdy;
        logic         exp_has;
        rsp_t         er;
        logic         e_rd;
        logic [31:0]  e_a;
        logic [31:0]  cur;

        @(negedge clk);
        rst       = rst_r;
        cfg_rr_en = cfg_r;
        for (int i = 0; i < N; i++) begin
            bus.req_vld[i]               = pend[i];
            bus.req_wr_en[i]             = p_wr[i];
            bus.req_addr[i*AW +: AW]     = p_addr[i];
            bus.req_wr_data[i*DW +: DW]  = p_data[i];
            bus.req_wr_byte_en[i*4 +: 4] = p_be[i];
            bus.req_sideband[i*SBW +: SBW] = p_sb[i];
        end
        #1;

        // Prediction
        win = -1;
        if (!rst_r) begin
            if (!cfg_r)
                for (int i = 0; i < N; i++)
                    if (win < 0 && pend[i] && m_wcnt[i] == MW) win = i;
            for (int k = 0; k < N; k++) begin
                int j;
                j = cfg_r ? (m_rr + k) % N : k;
                if (win < 0 && pend[j]) win = j;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        exp_has = !rst_r && exp_q.size() > 0 && exp_q[0].due == cyc;
        if (exp_has) er = exp_q[0];

        // Compare
        obs_rdy = bus.req_rdy;
        chk("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
        chk("mem_en", 64'(bus.mem_en), 64'(win >= 0));
        if (win >= 0) begin
            chk("mem_addr", 64'(bus.mem_addr), 64'(p_addr[win]));
            chk("mem_wr_en", 64'(bus.mem_wr_en), 64'(p_wr[win]));
            chk("mem_wr_data", 64'(bus.mem_wr_data), 64'(p_data[win]));
            chk("mem_be", 64'(bus.mem_wr_byte_en), 64'(p_be[win]));
        end else begin
            chk("mem_idle", {bus.mem_addr, bus.mem_wr_data} | 64'({bus.mem_wr_byte_en, bus.mem_wr_en}), 64'd0);
        end
        if (exp_has) begin
            chk("rsp_vld", 64'(bus.rsp_vld), 64'(1) << er.src);
            chk("rsp_data", 64'(bus.rsp_data), 64'(er.data));
            chk("rsp_sb", 64'(bus.rsp_sideband), 64'(er.sb));
            void'(exp_q.pop_front());
        end else begin
            chk("rsp_idle", {24'd0, bus.rsp_vld, bus.rsp_sideband, bus.rsp_data}, 64'd0);
        end
        if (bus.rsp_vld != '0) begin
            rsp_log.push_back(bus.rsp_vld);
            for (int i = 0; i < N; i++) if (bus.rsp_vld[i]) last_rsp_data[i] = bus.rsp_data;
        end

        // Memory environment sees the DUT's actual port
        e_rd = bus.mem_en && !bus.mem_wr_en;
        e_a  = bus.mem_addr;
        if (bus.mem_en && bus.mem_wr_en) begin
            cur = e_mem.exists(e_a) ? e_mem[e_a] : init_val(e_a);
            e_mem[e_a] = merge(cur, bus.mem_wr_data, bus.mem_wr_byte_en);
        end

        @(posedge clk);
        for (int k = LAT - 1; k > 0; k--) e_pipe[k] = e_pipe[k-1];
        e_pipe[0] = e_rd ? (e_mem.exists(e_a) ? e_mem[e_a] : init_val(e_a)) : $urandom;

        // Model state update
        if (rst_r) begin
            m_rr = 0;
            for (int i = 0; i < N; i++) m_wcnt[i] = 0;
            exp_q.delete();
        end else begin
            for (int i = 0; i < N; i++)
                m_wcnt[i] = (pend[i] && win != i) ? ((m_wcnt[i] < MW) ? m_wcnt[i] + 1 : MW) : 0;
            if (win >= 0) begin
                m_rr = (win + 1) % N;
                cur = m_mem.exists(p_addr[win]) ? m_mem[p_addr[win]] : init_val(p_addr[win]);
                if (p_wr[win]) m_mem[p_addr[win]] = merge(cur, p_data[win], p_be[win]);
                else exp_q.push_back('{cyc + LAT, win, p_sb[win], cur});
                pend[win] = 1'b0;
            end
        end
        cyc++;
        #1;
        bus.mem_rd_data = e_pipe[LAT-1];
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (pend[0] || pend[1] || exp_q.size() > 0); k++) cycle();
        chk("drain_timeout", 64'(pend[0] || pend[1] || exp_q.size() > 0), 64'd0);
        cycle();
    endtask

    initial begin
        int n;
        int cnt[N];
        logic seen;

        rst = 1'b1; cfg_rr_en = 1'b1; rst_r = 1'b1; cfg_r = 1'b1;
        bus.req_vld = '0; bus.req_wr_en = '0; bus.req_addr = '0; bus.req_wr_data = '0;
        bus.req_wr_byte_en = '0; bus.req_sideband = '0; bus.mem_rd_data = '0;
        for (int k = 0; k < LAT; k++) e_pipe[k] = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
            p_be[i] = '0; p_sb[i] = '0; m_wcnt[i] = 0; last_rsp_data[i] = '0;
        end
        m_rr = 0;

        // Reset held 3 cycles with both requesting; first grant right after
        post(0, 1'b0, 32'h10, 32'h0, 4'h0, 8'hA0);
        post(1, 1'b0, 32'h14, 32'h0, 4'h0, 8'hA1);
        for (int k = 0; k < 3; k++) cycle();
        rst_r = 1'b0;
        cycle();
        chk("post_rst_grant", 64'(obs_rdy != '0), 64'd1);
        drain();

        // Round-robin contention: 4 reads each
        cfg_r = 1'b1;
        cnt[0] = 0; cnt[1] = 0;
        for (int k = 0; k < 20 && (cnt[0] < 4 || cnt[1] < 4 || pend[0] || pend[1]); k++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && cnt[i] < 4) begin
                    post(i, 1'b0, 32'(64 * i + 4 * cnt[i]), 32'h0, 4'h0, 8'(16 * i + cnt[i]));
                    cnt[i]++;
                end
            seen = pend[0] && pend[1];
            cycle();
            if (seen) chk("rr_one_winner", 64'($countones(obs_rdy)), 64'd1);
        end
        drain();

        // Fixed-priority starvation: req1 forced in on the 8th cycle
        cfg_r = 1'b0;
        post(0, 1'b0, 32'h20, 32'h0, 4'h0, 8'h30);
        post(1, 1'b0, 32'h24, 32'h0, 4'h0, 8'h31);
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            if (!pend[0]) post(0, 1'b0, 32'h20, 32'h0, 4'h0, 8'h30);
            cycle();
            if (obs_rdy[1]) n = k;
        end
        chk("starve_cycle", 64'(n), 64'd8);
        if (!pend[0]) post(0, 1'b0, 32'h20, 32'h0, 4'h0, 8'h32);
        cycle();
        chk("starve_resume", 64'(obs_rdy), 64'b01);
        drain();

        // Write then read at 0x100 from requester 1
        post(1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 8'h55);
        cycle();
        post(1, 1'b0, 32'h100, 32'h0, 4'h0, 8'h56);
        rsp_log.delete();
        drain();
        chk("wr_rd_data", 64'(last_rsp_data[1]), 64'hDEAD_BEEF);
        chk("wr_rd_src", 64'(rsp_log.size() == 1 ? rsp_log[0] : 2'b00), 64'b10);

        // Back-to-back mixed sources
        rsp_log.delete();
        post(0, 1'b0, 32'h40, 32'h0, 4'h0, 8'hC0); cycle();
        post(1, 1'b0, 32'h44, 32'h0, 4'h0, 8'hC1); cycle();
        post(0, 1'b0, 32'h48, 32'h0, 4'h0, 8'hC2); cycle();
        drain();
        chk("b2b_count", 64'(rsp_log.size()), 64'd3);
        if (rsp_log.size() == 3) begin
            chk("b2b_0", 64'(rsp_log[0]), 64'b01);
            chk("b2b_1", 64'(rsp_log[1]), 64'b10);
            chk("b2b_2", 64'(rsp_log[2]), 64'b01);
        end

        // Reset with two reads in flight
        post(0, 1'b0, 32'h50, 32'h0, 4'h0, 8'hE0); cycle();
        post(1, 1'b0, 32'h54, 32'h0, 4'h0, 8'hE1); cycle();
        rsp_log.delete();
        rst_r = 1'b1; cycle();
        rst_r = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        chk("flush_rsp", 64'(rsp_log.size()), 64'd0);

        // Random traffic with occasional mode changes and resets
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) cfg_r = ~cfg_r;
            rst_r = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 9) < 6) post_rand(i);
            cycle();
        end
        rst_r = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/toy_dtcm_arb.md
Name: toy_dtcm_arb

Overview:
- Shares the single DTCM data-memory port between NUM_REQ requesters: requester 0 is the LSU, requester 1 is the debug/DMA port.
- Arbitrates at most one access per cycle and drives the memory enable, address, write and sideband signals.
- Tracks in-flight reads through a fixed-latency pipeline and returns each read's data and sideband only to the requester that issued it.
- Sits between the LSU/debug logic and toy_mem_top's dtcm_mem_* port.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 has the highest fixed priority.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, memory data width.
- SB_WIDTH, 8, request/response sideband width.
- RD_LAT, 2, cycles from grant of a read to rd_data valid at the memory; legal range 1..4.
- MAX_WAIT, 7, in fixed-priority mode, the number of consecutive lost cycles after which a waiting requester is forced in.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cfg_rr_en  in  1  1 = round-robin arbitration; 0 = fixed priority with anti-starvation.
- req_vld  in  NUM_REQ  per-requester request valid.
- req_rdy  out  NUM_REQ  per-requester grant; the request is accepted when vld&rdy.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed; slice i belongs to requester i.
- req_wr_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_wr_byte_en  in  NUM_REQ*DATA_WIDTH/8  packed byte enables.
- req_wr_en  in  NUM_REQ  1 = write, 0 = read.
- req_sideband  in  NUM_REQ*SB_WIDTH  packed; returned with read data.
- rsp_vld  out  NUM_REQ  one-hot read response valid; there is no backpressure.
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters.
- rsp_sideband  out  SB_WIDTH  sideband of the returned read.
- mem_en  out  1  memory enable.
- mem_addr  out  ADDR_WIDTH
- mem_wr_data  out  DATA_WIDTH
- mem_wr_byte_en  out  DATA_WIDTH/8
- mem_wr_en  out  1
- mem_rd_data  in  DATA_WIDTH  valid exactly RD_LAT cycles after a read grant.

Behaviour:
- Reset:
  - All registers clear synchronously.
  - rr_ptr = 0.
  - Wait counters = 0.
  - Read pipeline valid bits = 0.
  - Outputs while rst is high: req_rdy = 0, rsp_vld = 0, mem_en = 0; mem_addr, mem_wr_data, mem_wr_byte_en, mem_wr_en = 0; rsp_data and rsp_sideband = 0.
- Grant logic:
  - Combinational from req_vld and state; at most one req_rdy bit is set per cycle.
  - Grant is zero-cycle: req_rdy may be high in the same cycle req_vld rises.
- Memory drive:
  - On a grant: mem_en = 1, and mem_addr / wr_data / wr_byte_en / wr_en are muxed from the granted slice in the same cycle.
  - With no grant, mem_en = 0 and the mem outputs are 0.
- Round-robin (cfg_rr_en = 1):
  - Search starts at rr_ptr.
  - After a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no grant.
- Fixed priority (cfg_rr_en = 0):
  - The lowest index wins.
  - Per requester, wait_cnt[i] increments, saturating at MAX_WAIT, on each cycle req_vld[i] & ~req_rdy[i]. It clears when requester i is granted or deasserts vld.
  - Any requester with wait_cnt == MAX_WAIT wins over normal priority. Among several starved requesters, the lowest index wins.
  - rr_ptr still updates on every grant, so switching mode mid-stream is glitch-free.
- Writes:
  - Complete at grant.
  - No response is generated.
- Reads:
  - Each read grant pushes {valid, src index, sideband} into a RD_LAT-deep shift pipeline.
  - When an entry exits the pipeline, rsp_vld[src] = 1, rsp_data = mem_rd_data, rsp_sideband = the stored sideband, all in the same cycle mem_rd_data is valid.
  - Responses return strictly in grant order.
  - One read is accepted per cycle sustained, so up to RD_LAT reads are in flight.
- Ordering: a write and a later read to the same address are serialized by grant order, so the read returns the new data.
- Request stability: the requester holds its request fields stable while vld is high and rdy is low. The arbiter does not latch unaccepted requests.
- Reset during operation: in-flight reads are discarded with no rsp_vld. Requesters must reissue.
- cfg_rr_en change: takes effect in the same cycle. Wait counters are kept.
- Width rule: the rr_ptr width is $clog2(NUM_REQ), with a minimum of 1.

Test Plan:
- Reset: hold rst for 3 cycles with req_vld = 2'b11 -> req_rdy = 0, mem_en = 0, rsp_vld = 0 throughout; first grant appears in the cycle after rst falls.
- RR contention: cfg_rr_en = 1, both requesters issue 4 reads each continuously -> grants alternate 0,1,0,1,...; each rsp_vld arrives exactly 2 cycles after its grant with the matching sideband.
- Fixed-priority starvation: cfg_rr_en = 0, req 0 always valid, req 1 valid from cycle 0 -> req 1 is granted on the 8th cycle (wait_cnt reaches 7), then req 0 resumes.
- Write then read: req 1 writes 0xDEADBEEF to 0x100 with byte_en 4'hF, then reads 0x100 -> rsp_vld[1] with rsp_data 0xDEADBEEF and no rsp_vld[0].
- Back-to-back reads from mixed sources: 0@A, 1@B, 0@C on consecutive cycles -> rsp_vld sequence 01,10,01 on cycles +2,+3,+4, with correct sidebands.
- Mid-flight reset: assert rst 1 cycle after 2 read grants -> no rsp_vld is ever emitted for them.
